// File: rtl/priority_arbiter.sv
// Registered N-way arbiter with grant locking, fixed-priority or round-robin
// selection, and an optional per-tenure hold limit.
module priority_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hcnt_q, hcnt_d;

    logic [IW-1:0] fixWin, rrWin, win;
    logic          timeout, decide;

    always_comb begin
        fixWin = '0;
        for (int i = 0; i < N; i++) begin
            if (req[IW'(i)]) fixWin = IW'(i);
        end
    end

    // Walk from the farthest candidate back toward ptr so the last hit is the
    // first set bit in the order ptr, ptr-1, ... (mod N).
    always_comb begin
        int            pos;
        logic [IW-1:0] p;
        rrWin = '0;
        pos   = 0;
        p     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr_q) - k;
            if (pos < 0) pos = pos + N;
            p = IW'(pos);
            if (req[p]) rrWin = p;
        end
    end

    assign win     = mode ? rrWin : fixWin;
    assign timeout = (MAX_HOLD > 0) && (hcnt_q == HW'(MAX_HOLD));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        decide  = 1'b0;

        case (state_q)
            IDLE: decide = |req;
            BUSY: begin
                if (!req[idx_q] || timeout) begin
                    decide = 1'b1;
                end else if (MAX_HOLD > 0) begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Release and timeout both arbitrate over the raw request vector; on
        // timeout the owner stays eligible.
        if (decide) begin
            if (|req) begin
                state_d    = BUSY;
                gnt_d      = '0;
                gnt_d[win] = 1'b1;
                idx_d      = win;
                hcnt_d     = HW'(1);
                if (mode) ptr_d = (win == '0) ? IW'(N - 1) : win - IW'(1);
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
                hcnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= IW'(N - 1);
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_idx   = idx_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Scoreboard bench for priority_arbiter: three N=4 instances differing only in
// MAX_HOLD (0, 2, 3) share stimulus; each scenario checks the relevant one.
module tb_priority_arbiter;

    logic       clk;
    logic       reset;
    logic       mode;
    logic [3:0] req;

    logic [3:0] gnt0, gnt2, gnt3;
    logic       valid0, valid2, valid3;
    logic [1:0] idx0, idx2, idx3;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
    } exp_t;

    exp_t sbQ[$];
    int   nChecks;
    int   nFails;

    priority_arbiter #(.N(4), .MAX_HOLD(0)) u0 (
        .clk(clk), .reset(reset), .mode(mode), .req(req),
        .gnt(gnt0), .gnt_valid(valid0), .gnt_idx(idx0)
    );

    priority_arbiter #(.N(4), .MAX_HOLD(2)) u2 (
        .clk(clk), .reset(reset), .mode(mode), .req(req),
        .gnt(gnt2), .gnt_valid(valid2), .gnt_idx(idx2)
    );

    priority_arbiter #(.N(4), .MAX_HOLD(3)) u3 (
        .clk(clk), .reset(reset), .mode(mode), .req(req),
        .gnt(gnt3), .gnt_valid(valid3), .gnt_idx(idx3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] ei);
        exp_t e;
        req   = r;
        e.gnt = eg;
        e.idx = ei;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        req   = 4'b0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        mode  = 1'b0;
        reset = 1'b1;
        applyStimulus(4'b1111, 4'b0000, 2'd0);
        e = sbQ.pop_front();
        nChecks++;
        if (gnt0 !== e.gnt || valid0 !== 1'b0 || idx0 !== e.idx) begin
            nFails++;
            $display("[TB] FAIL reset_state gnt=%b valid=%b idx=%0d expected gnt=%b valid=0 idx=%0d",
                     gnt0, valid0, idx0, e.gnt, e.idx);
        end
        reset = 1'b0;
        applyStimulus(4'b1111, 4'b1000, 2'd3);
        e = sbQ.pop_front();
        nChecks++;
        if (gnt0 !== e.gnt || valid0 !== 1'b1 || idx0 !== e.idx) begin
            nFails++;
            $display("[TB] FAIL reset_first_grant gnt=%b valid=%b idx=%0d expected gnt=%b valid=1 idx=%0d",
                     gnt0, valid0, idx0, e.gnt, e.idx);
        end
    endtask

    task automatic test_fixed_priority();
        logic [3:0] reqs [7] = '{4'b0101, 4'b0000, 4'b0011, 4'b0000, 4'b1111, 4'b0000, 4'b0001};
        logic [3:0] gnts [7] = '{4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        logic [1:0] idxs [7] = '{2'd2,    2'd0,    2'd1,    2'd0,    2'd3,    2'd0,    2'd0};
        exp_t e;
        doReset();
        mode = 1'b0;
        for (int s = 0; s < 7; s++) begin
            applyStimulus(reqs[s], gnts[s], idxs[s]);
            e = sbQ.pop_front();
            nChecks++;
            if (gnt0 !== e.gnt || valid0 !== (|e.gnt)) begin
                nFails++;
                $display("[TB] FAIL fixed_gnt step %0d gnt=%b valid=%b expected gnt=%b", s, gnt0, valid0, e.gnt);
            end
            if (|e.gnt) begin
                nChecks++;
                if (idx0 !== e.idx) begin
                    nFails++;
                    $display("[TB] FAIL fixed_idx step %0d idx=%0d expected %0d", s, idx0, e.idx);
                end
            end
        end
        nChecks++;
        if (u0.ptr_q !== 2'd3) begin
            nFails++;
            $display("[TB] FAIL fixed_ptr_unchanged ptr=%0d expected 3", u0.ptr_q);
        end
    endtask

    task automatic test_no_preempt();
        logic [3:0] reqs [5] = '{4'b0010, 4'b0110, 4'b0110, 4'b0100, 4'b0100};
        logic [3:0] gnts [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
        logic [1:0] idxs [5] = '{2'd1,    2'd1,    2'd1,    2'd2,    2'd2};
        exp_t e;
        doReset();
        mode = 1'b0;
        for (int s = 0; s < 5; s++) begin
            applyStimulus(reqs[s], gnts[s], idxs[s]);
            e = sbQ.pop_front();
            nChecks++;
            if (gnt0 !== e.gnt || valid0 !== 1'b1 || idx0 !== e.idx) begin
                nFails++;
                $display("[TB] FAIL no_preempt step %0d gnt=%b valid=%b idx=%0d expected gnt=%b valid=1 idx=%0d",
                         s, gnt0, valid0, idx0, e.gnt, e.idx);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] gnts [10] = '{4'b1000, 4'b1000, 4'b0100, 4'b0100, 4'b0010,
                                  4'b0010, 4'b0001, 4'b0001, 4'b1000, 4'b1000};
        logic [1:0] idxs [10] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd3, 2'd3};
        exp_t e;
        doReset();
        mode = 1'b1;
        for (int s = 0; s < 10; s++) begin
            applyStimulus(4'b1111, gnts[s], idxs[s]);
            e = sbQ.pop_front();
            nChecks++;
            if (gnt2 !== e.gnt || valid2 !== 1'b1 || idx2 !== e.idx) begin
                nFails++;
                $display("[TB] FAIL rr_rotate step %0d gnt=%b valid=%b idx=%0d expected gnt=%b valid=1 idx=%0d",
                         s, gnt2, valid2, idx2, e.gnt, e.idx);
            end
        end
    endtask

    task automatic test_rr_release();
        logic [3:0] reqs [4] = '{4'b1001, 4'b0001, 4'b0000, 4'b1001};
        logic [3:0] gnts [4] = '{4'b1000, 4'b0001, 4'b0000, 4'b1000};
        logic [1:0] idxs [4] = '{2'd3,    2'd0,    2'd0,    2'd3};
        logic [1:0] ptrs [4] = '{2'd2,    2'd3,    2'd3,    2'd2};
        exp_t e;
        doReset();
        mode = 1'b1;
        for (int s = 0; s < 4; s++) begin
            applyStimulus(reqs[s], gnts[s], idxs[s]);
            e = sbQ.pop_front();
            nChecks++;
            if (gnt0 !== e.gnt || valid0 !== (|e.gnt)) begin
                nFails++;
                $display("[TB] FAIL rr_release_gnt step %0d gnt=%b valid=%b expected gnt=%b", s, gnt0, valid0, e.gnt);
            end
            if (|e.gnt) begin
                nChecks++;
                if (idx0 !== e.idx) begin
                    nFails++;
                    $display("[TB] FAIL rr_release_idx step %0d idx=%0d expected %0d", s, idx0, e.idx);
                end
            end
            nChecks++;
            if (u0.ptr_q !== ptrs[s]) begin
                nFails++;
                $display("[TB] FAIL rr_release_ptr step %0d ptr=%0d expected %0d", s, u0.ptr_q, ptrs[s]);
            end
        end
    endtask

    task automatic test_hold_limit();
        logic [1:0] hcnts [7] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
        exp_t e;
        doReset();
        mode = 1'b0;
        for (int s = 0; s < 7; s++) begin
            applyStimulus(4'b1000, 4'b1000, 2'd3);
            e = sbQ.pop_front();
            nChecks++;
            if (gnt3 !== e.gnt || valid3 !== 1'b1 || idx3 !== e.idx) begin
                nFails++;
                $display("[TB] FAIL hold_gnt step %0d gnt=%b valid=%b idx=%0d expected gnt=%b valid=1 idx=%0d",
                         s, gnt3, valid3, idx3, e.gnt, e.idx);
            end
            nChecks++;
            if (u3.hcnt_q !== hcnts[s]) begin
                nFails++;
                $display("[TB] FAIL hold_hcnt step %0d hcnt=%0d expected %0d", s, u3.hcnt_q, hcnts[s]);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        doReset();
        mode = 1'b1;
        applyStimulus(4'b0100, 4'b0100, 2'd2);
        e = sbQ.pop_front();
        nChecks++;
        if (gnt0 !== e.gnt || idx0 !== e.idx || u0.ptr_q !== 2'd1) begin
            nFails++;
            $display("[TB] FAIL mid_setup gnt=%b idx=%0d ptr=%0d expected gnt=%b idx=%0d ptr=1",
                     gnt0, idx0, u0.ptr_q, e.gnt, e.idx);
        end
        reset = 1'b1;
        applyStimulus(4'b0100, 4'b0000, 2'd0);
        e = sbQ.pop_front();
        nChecks++;
        if (gnt0 !== e.gnt || valid0 !== 1'b0 || idx0 !== e.idx || u0.ptr_q !== 2'd3) begin
            nFails++;
            $display("[TB] FAIL mid_reset gnt=%b valid=%b idx=%0d ptr=%0d expected gnt=%b valid=0 idx=%0d ptr=3",
                     gnt0, valid0, idx0, u0.ptr_q, e.gnt, e.idx);
        end
        reset = 1'b0;
        applyStimulus(4'b0100, 4'b0100, 2'd2);
        e = sbQ.pop_front();
        nChecks++;
        if (gnt0 !== e.gnt || valid0 !== 1'b1 || idx0 !== e.idx) begin
            nFails++;
            $display("[TB] FAIL mid_regrant gnt=%b valid=%b idx=%0d expected gnt=%b valid=1 idx=%0d",
                     gnt0, valid0, idx0, e.gnt, e.idx);
        end
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        reset   = 1'b1;
        mode    = 1'b0;
        req     = 4'b0000;
        @(posedge clk);
        #1;
        test_reset();
        test_fixed_priority();
        test_no_preempt();
        test_round_robin();
        test_rr_release();
        test_hold_limit();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
